vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 30 +++
 rtl/vram_wr_fifo.sv | 67 ++++++
 rtl/vram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// ============================================================================
// Module : vram_arbiter_pkg
// Brief  : Shared geometry, clear fill code, queue entry type and arbiter FSM
//          encoding for the text-mode VRAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_arbiter_pkg;

  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 30;
  localparam int unsigned VRAM_DEPTH = COLS * ROWS;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  BLANK_CHAR = 8'h20;
  localparam int unsigned ENTRY_W    = 20;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/vram_wr_fifo.sv
// ============================================================================
// Module : vram_wr_fifo
// Brief  : Small synchronous write queue; full/empty come from an occupancy
//          count so a same-cycle pop never makes a full queue look ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rptr + c_PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module : vram_arbiter
// Brief  : Single-port VRAM arbiter: display fetches own every eighth active
//          pixel, queued CPU writes and screen clears use the remaining cycles.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned COLS       = vram_arbiter_pkg::COLS,
  parameter int unsigned ROWS       = vram_arbiter_pkg::ROWS,
  parameter int unsigned FIFO_DEPTH = vram_arbiter_pkg::FIFO_DEPTH,
  parameter logic [7:0]  BLANK_CHAR = vram_arbiter_pkg::BLANK_CHAR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        clr_start,
  output logic        busy,
  output logic        drop_err,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code,
  output logic        char_strobe
);

  localparam logic [11:0] c_LAST_ADDR = 12'(COLS * ROWS - 1);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic [11:0] r_clr_cnt;
  logic [11:0] w_cnt_nxt;
  logic        r_ram_we;
  logic [11:0] r_ram_addr;
  logic [7:0]  r_ram_wdata;
  logic        w_we_nxt;
  logic [11:0] w_addr_nxt;
  logic [7:0]  w_wdata_nxt;
  logic        r_disp_d1;
  logic        r_disp_d2;
  logic        r_char_strobe;
  logic [7:0]  r_char_code;
  logic        r_drop_err;
  logic        w_drop;
  logic        w_pop;
  logic        w_push;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  wr_entry_t   w_head;
  logic        w_disp_slot;
  logic [11:0] w_disp_addr;
  logic        w_unused;

  // Pixel row is 16 lines high and 8 pixels wide; the constant multiply folds to shift-add.
  assign w_disp_slot = valid && (h_addr[2:0] == 3'd0);
  assign w_disp_addr = 12'(v_addr[9:4]) * 12'(COLS) + 12'(h_addr[9:3]);
  assign w_unused    = ^v_addr[3:0];

  assign w_push   = wr_valid && wr_ready;
  assign wr_ready = reset_n && !w_fifo_full;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({wr_addr, wr_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_clr_cnt;
    w_pop       = 1'b0;
    w_drop      = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_ram_addr;
    w_wdata_nxt = r_ram_wdata;
    if (w_disp_slot) begin
      w_addr_nxt = w_disp_addr;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            w_pop = 1'b1;
            if (w_head.addr <= c_LAST_ADDR) begin
              w_we_nxt    = 1'b1;
              w_addr_nxt  = w_head.addr;
              w_wdata_nxt = w_head.data;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_clr_cnt;
          w_wdata_nxt = BLANK_CHAR;
          if (r_clr_cnt == c_LAST_ADDR) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_clr_cnt + 12'd1;
          end
        end
        default: ;
      endcase
    end
    if ((r_state == ST_IDLE) && clr_start) begin
      w_state_nxt = ST_CLEAR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_cnt     <= '0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_wdata   <= '0;
      r_disp_d1     <= 1'b0;
      r_disp_d2     <= 1'b0;
      r_char_strobe <= 1'b0;
      r_char_code   <= '0;
      r_drop_err    <= 1'b0;
    end else begin
      r_clr_cnt     <= w_cnt_nxt;
      r_ram_we      <= w_we_nxt;
      r_ram_addr    <= w_addr_nxt;
      r_ram_wdata   <= w_wdata_nxt;
      // Fetch pipeline: address out at T+1, RAM data valid at T+2, strobe at T+3.
      r_disp_d1     <= w_disp_slot;
      r_disp_d2     <= r_disp_d1;
      r_char_strobe <= r_disp_d2;
      if (r_disp_d2) begin
        r_char_code <= ram_rdata;
      end
      r_drop_err <= r_drop_err | w_drop;
    end
  end

  assign busy        = (r_state == ST_CLEAR);
  assign drop_err    = r_drop_err;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign char_code   = r_char_code;
  assign char_strobe = r_char_strobe;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module : tb_vram_arbiter
// Brief  : Directed self-checking bench for vram_arbiter with a behavioural
//          synchronous-read VRAM and a log of every RAM write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        clr_start;
  logic        busy;
  logic        drop_err;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_strobe;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_addr      (h_addr),
    .v_addr      (v_addr),
    .valid       (valid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_start   (clr_start),
    .busy        (busy),
    .drop_err    (drop_err),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .char_code   (char_code),
    .char_strobe (char_strobe)
  );

  // Behavioural VRAM plus a bench-side preload port used only while the DUT is idle.
  logic [7:0]  mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  logic [11:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          slot_viol = 0;
  logic        slot_q = 1'b0;

  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
      if (slot_q) slot_viol++;
    end
    slot_q <= valid && (h_addr[2:0] == 3'd0);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ a[11:4];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},     32'(ram_we), 0);
    check({tag, "_addr"},   32'(ram_addr), 0);
    check({tag, "_wdata"},  32'(ram_wdata), 0);
    check({tag, "_char"},   32'(char_code), 0);
    check({tag, "_strobe"}, 32'(char_strobe), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_drop"},   32'(drop_err), 0);
    check({tag, "_ready"},  32'(wr_ready), 0);
  endtask

  typedef struct {
    logic        vld;
    logic [9:0]  v;
    logic [9:0]  h;
    logic [7:0]  d;
    logic        slot;
    logic [11:0] ea;
  } dvec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dvec_t       dv [7];
    int          base;
    int          k;
    int          errs;
    int          strobes;
    logic        ok;
    logic [7:0]  exp_q [$];
    int          lines [6];

    dv[0] = '{1'b1, 10'd35,  10'd16,  8'h41, 1'b1, 12'd162};
    dv[1] = '{1'b1, 10'd0,   10'd0,   8'h5A, 1'b1, 12'd0};
    dv[2] = '{1'b1, 10'd16,  10'd639, 8'h00, 1'b0, 12'd0};
    dv[3] = '{1'b1, 10'd479, 10'd632, 8'hC3, 1'b1, 12'd2399};
    dv[4] = '{1'b0, 10'd0,   10'd0,   8'h00, 1'b0, 12'd2399};
    dv[5] = '{1'b1, 10'd15,  10'd8,   8'h7E, 1'b1, 12'd1};
    dv[6] = '{1'b1, 10'd255, 10'd320, 8'h99, 1'b1, 12'd1240};
    lines = '{0, 15, 16, 239, 464, 479};

    reset_n = 1'b0; h_addr = '0; v_addr = '0; valid = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_start = 1'b0;
    tick(); tick();
    check_reset_outputs("rst0");
    reset_n = 1'b1;
    #1;
    check("rst0_ready_after", 32'(wr_ready), 1);

    // Display fetch vectors
    for (int i = 0; i < 7; i++) begin
      if (dv[i].slot) begin
        pre_we = 1'b1; pre_addr = dv[i].ea; pre_data = dv[i].d;
        tick();
        pre_we = 1'b0;
      end
      valid = dv[i].vld; v_addr = dv[i].v; h_addr = dv[i].h;
      tick();
      check($sformatf("disp%0d_addr", i), 32'(ram_addr), 32'(dv[i].ea));
      check($sformatf("disp%0d_we", i), 32'(ram_we), 0);
      valid = 1'b0;
      tick();
      check($sformatf("disp%0d_strobe_t2", i), 32'(char_strobe), 0);
      tick();
      check($sformatf("disp%0d_strobe_t3", i), 32'(char_strobe), 32'(dv[i].slot));
      if (dv[i].slot) check($sformatf("disp%0d_char", i), 32'(char_code), 32'(dv[i].d));
      tick();
      check($sformatf("disp%0d_strobe_t4", i), 32'(char_strobe), 0);
    end

    // Fill the queue while every cycle is a display slot, then drain it
    base = log_addr.size();
    valid = 1'b1; v_addr = '0; h_addr = '0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill%0d_ready", i), 32'(wr_ready), 1);
      wr_valid = 1'b1; wr_addr = 12'(200 + i); wr_data = 8'(8'hA0 + i);
      tick();
    end
    check("fill_full_ready", 32'(wr_ready), 0);
    wr_addr = 12'd204; wr_data = 8'hA4;
    tick(); tick();
    check("fill_no_pop_in_slots", 32'(log_addr.size() - base), 0);
    ok = 1'b0;
    k = 1;
    while (!ok && k < 60) begin
      h_addr = 10'(k);
      ok = wr_ready;
      tick();
      k++;
    end
    wr_valid = 1'b0;
    check("fill_fifth_accepted", 32'(ok), 1);
    while ((log_addr.size() - base) < 5 && k < 200) begin
      h_addr = 10'(k);
      tick();
      k++;
    end
    valid = 1'b0;
    check("fill_write_count", 32'(log_addr.size() - base), 5);
    errs = 0;
    for (int i = 0; i < 5 && base + i < log_addr.size(); i++) begin
      if (log_addr[base + i] != 12'(200 + i) || log_data[base + i] != 8'(8'hA0 + i)) errs++;
      if (mem[200 + i] != 8'(8'hA0 + i)) errs++;
    end
    check("fill_order_and_data", 32'(errs), 0);
    check("fill_slot_plus1_writes", 32'(slot_viol), 0);

    // Screen clear with a write pushed mid-clear and an ignored second clr_start
    tick();
    base = log_addr.size();
    clr_start = 1'b1;
    check("clr_busy_pulse_cycle", 32'(busy), 0);
    tick();
    clr_start = 1'b0;
    check("clr_busy_next", 32'(busy), 1);
    k = 0;
    while (busy && k < 3000) begin
      wr_valid = (k == 500); wr_addr = 12'd100; wr_data = 8'h55;
      clr_start = (k == 1000);
      tick();
      k++;
    end
    wr_valid = 1'b0; clr_start = 1'b0;
    check("clr_done", 32'(busy), 0);
    check("clr_last_we", 32'(ram_we), 1);
    check("clr_last_addr", 32'(ram_addr), 2399);
    check("clr_last_data", 32'(ram_wdata), 32'h20);
    tick(); tick(); tick();
    check("clr_total_writes", 32'(log_addr.size() - base), 2401);
    errs = 0;
    for (int i = 0; i < 2400 && base + i < log_addr.size(); i++) begin
      if (log_addr[base + i] != 12'(i) || log_data[base + i] != 8'h20) errs++;
    end
    check("clr_sequence", 32'(errs), 0);
    if (log_addr.size() == base + 2401) begin
      check("clr_after_addr", 32'(log_addr[base + 2400]), 100);
      check("clr_after_data", 32'(log_data[base + 2400]), 32'h55);
    end else begin
      check("clr_after_present", 32'(log_addr.size() - base), 2401);
    end
    check("clr_mem100", 32'(mem[100]), 32'h55);
    check("clr_mem2399", 32'(mem[2399]), 32'h20);

    // Out-of-range write is dropped and flagged
    base = log_addr.size();
    check("drop_before", 32'(drop_err), 0);
    wr_valid = 1'b1; wr_addr = 12'd2400; wr_data = 8'h11;
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    check("drop_no_write", 32'(log_addr.size() - base), 0);
    check("drop_flag", 32'(drop_err), 1);
    wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0;
    tick(); tick(); tick();
    check("drop_next_count", 32'(log_addr.size() - base), 1);
    check("drop_next_mem", 32'(mem[5]), 32'h77);
    check("drop_sticky", 32'(drop_err), 1);

    // Reset in the middle of a clear with queued writes
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 12'(300 + i); wr_data = 8'(8'hB0 + i);
      tick();
    end
    wr_valid = 1'b0;
    k = 0;
    while (!(ram_we && ram_addr == 12'd1000) && k < 1500) begin
      tick();
      k++;
    end
    check("abort_reached_1000", 32'(ram_addr), 1000);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick(); tick();
    reset_n = 1'b1;
    #1;
    check("abort_ready_after", 32'(wr_ready), 1);
    base = log_addr.size();
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_writes", 32'(log_addr.size() - base), 0);
    check("abort_idle", 32'(busy), 0);

    // Active-line fetch sweep over representative lines
    for (int a = 0; a < 2400; a++) begin
      pre_we = 1'b1; pre_addr = 12'(a); pre_data = pat(12'(a));
      tick();
    end
    pre_we = 1'b0;
    for (int li = 0; li < 6; li++) begin
      strobes = 0;
      errs = 0;
      for (int h = 0; h < 648; h++) begin
        valid = (h < 640); v_addr = 10'(lines[li]); h_addr = 10'(h);
        if (h < 640 && (h % 8) == 0) exp_q.push_back(pat(12'((lines[li] / 16) * 80 + h / 8)));
        tick();
        if (char_strobe) begin
          strobes++;
          if (exp_q.size() == 0) errs++;
          else if (char_code != exp_q.pop_front()) errs++;
        end
      end
      check($sformatf("line%0d_strobes", lines[li]), 32'(strobes), 80);
      check($sformatf("line%0d_data", lines[li]), 32'(errs), 0);
    end
    valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
